// File: rtl/led_stack_pattern.sv
// ============================================================================
// Module  : led_stack_pattern
// Brief   : Stacking-light LED animation with 2-digit BCD fill counter and
//           internal step prescaler, feeding a TM1638 LED/7-seg driver.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module led_stack_pattern #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       run,
  input  logic       dir,
  output logic [7:0] led,
  output logic [7:0] fill_bcd,
  output logic       step_pulse
);

  localparam int                 c_DIV_W    = $clog2(TICK_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

  typedef enum logic [1:0] {
    S_MOVE  = 2'd0,
    S_FULL  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_fill, w_fill_nxt;
  logic [2:0]         r_pos, w_pos_nxt;
  logic [3:0]         r_ones, r_tens, w_ones_nxt, w_tens_nxt;
  logic [c_DIV_W-1:0] r_div_cnt;
  logic               w_tick, r_tick_d;
  logic [7:0]         w_pat, w_rev;

  assign w_tick   = run && (r_div_cnt == c_DIV_LAST);
  assign fill_bcd = {r_tens, r_ones};

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      r_div_cnt <= '0;
    end else if (run) begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + c_DIV_ONE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_pos_nxt   = r_pos;
    w_ones_nxt  = r_ones;
    w_tens_nxt  = r_tens;
    case (r_state)
      S_MOVE: begin
        if (w_tick) begin
          if ({1'b0, r_pos} > r_fill) begin
            w_pos_nxt = r_pos - 3'd1;
          end else begin
            w_fill_nxt = r_fill + 4'd1;
            if (r_fill == 4'd7) begin
              w_state_nxt = S_FULL;
            end else begin
              w_pos_nxt = 3'd7;
            end
          end
        end
      end
      S_FULL: begin
        if (w_tick) begin
          w_state_nxt = S_CLEAR;
          if (r_ones == 4'd9) begin
            w_ones_nxt = 4'd0;
            w_tens_nxt = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
          end else begin
            w_ones_nxt = r_ones + 4'd1;
          end
        end
      end
      S_CLEAR: begin
        if (w_tick) begin
          w_state_nxt = S_MOVE;
          w_fill_nxt  = 4'd0;
          w_pos_nxt   = 3'd7;
        end
      end
      default: begin
        w_state_nxt = S_MOVE;
        w_fill_nxt  = 4'd0;
        w_pos_nxt   = 3'd7;
      end
    endcase
  end

  // Stack occupies the low 'fill' bits; the moving light is OR-ed on top.
  always_comb begin
    w_pat = 8'h00;
    case (r_state)
      S_MOVE:  w_pat = (8'hFF >> (4'd8 - r_fill)) | (8'd1 << r_pos);
      S_FULL:  w_pat = 8'hFF;
      default: w_pat = 8'h00;
    endcase
    for (int i = 0; i < 8; i++) begin
      w_rev[i] = w_pat[7-i];
    end
  end

  // Strobe is delayed twice so it lines up with the led register update.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      r_state    <= S_MOVE;
      r_fill     <= 4'd0;
      r_pos      <= 3'd7;
      r_ones     <= 4'd0;
      r_tens     <= 4'd0;
      r_tick_d   <= 1'b0;
      step_pulse <= 1'b0;
      led        <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_fill     <= w_fill_nxt;
      r_pos      <= w_pos_nxt;
      r_ones     <= w_ones_nxt;
      r_tens     <= w_tens_nxt;
      r_tick_d   <= w_tick;
      step_pulse <= r_tick_d;
      led        <= dir ? w_rev : w_pat;
    end
  end

endmodule

`default_nettype wire
